ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Sequences the single byte-wide RAM port and shares it between two requesters: instruction fetch on an icache miss, and the MEM stage for loads and stores.
- Assembles 1/2/4-byte transfers byte-serially, little-endian.
- Returns fetched words to IF; the IF stage forwards them to the icache as its write/fill data.
- MEM has fixed priority over IF; a granted transaction is never preempted.

Parameters:
ADDR_WIDTH, 32, width of all address ports and of the internal address arithmetic

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
rdy  in  1  global ready; when 0, all internal state is frozen
if_req  in  1  IF fetch request; held until if_done, or dropped to abort
if_addr  in  ADDR_WIDTH  fetch address, 4 bytes read
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  32  fetched instruction word
mem_req  in  1  MEM request; held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_addr  in  ADDR_WIDTH  base address
mem_len  in  2  00 = byte, 01 = half, 10 = word, 11 = word
mem_wdata  in  32  store data; byte k is taken from [8k+7:8k]
mem_done  out  1  one-cycle pulse: transaction complete, mem_rdata valid for loads
mem_rdata  out  32  load data, zero-extended
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_wr  out  1  RAM write enable
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte, valid the cycle after its address is sampled by RAM
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst = 0) is asynchronous:
  - state = IDLE, counters = 0;
  - all outputs = 0, including ram_wr, if_done, mem_done, if_data, mem_rdata and busy;
  - a transaction in flight is discarded with no done pulse.
- States:
  - IDLE, RD, WR, DONE.
  - All outputs are registered.
  - Edges are only considered when rdy = 1. With rdy = 0, state and all outputs hold, except ram_wr, which is forced to 0.
- IDLE, at each edge:
  - If mem_req = 1: latch mem_addr, mem_len and mem_wdata; set owner = MEM; go to WR if mem_we = 1, else to RD.
  - Else if if_req = 1: latch if_addr; set length N = 4, owner = IF; go to RD.
  - Else stay in IDLE.
  - N = 1, 2 or 4 from mem_len.
- RD (edge E0 = grant edge):
  - ram_addr = base + k is driven after edge Ek, for k = 0..N-1.
  - Byte k is captured from ram_din at edge E(k+2) into bits [8k+7:8k].
  - The final capture, at E(N+1), also asserts the owner's done and moves to DONE.
  - The done pulse is therefore visible in the cycle after E(N+1); a word read occupies 5 cycles after the grant.
- WR:
  - After edge Ek, k = 0..N-1: ram_addr = base + k, ram_dout = byte k, ram_wr = 1.
  - At E(N): ram_wr = 0, mem_done = 1, go to DONE.
- DONE:
  - The done pulse is high for exactly this cycle.
  - Requests are not sampled; the state returns to IDLE at the next edge.
  - Requesters deassert req on seeing done, so no transaction is repeated.
- IF abort:
  - If if_req = 0 at any edge while owner = IF in RD, go straight to IDLE: no if_done, if_data unchanged.
  - A pending mem_req is sampled at the following edge.
  - MEM transactions cannot be aborted.
- Address arithmetic:
  - base + k wraps modulo 2^ADDR_WIDTH.
  - Misaligned addresses are legal and are handled byte-serially without special treatment.
- mem_rdata:
  - Bytes at and above N are 0.
  - Sign extension is done in the MEM stage, not here.
  - mem_rdata and if_data hold their value until overwritten by the next capture for the same owner.
- Simultaneous requests in IDLE: MEM wins. IF keeps requesting and is granted at the first IDLE edge where mem_req = 0.
- Request changes in RD/WR: ignored, except if_req falling while owner = IF.

Test Plan:
- Reset, then IF word fetch: if_addr = 0x1000, RAM bytes 0x13, 0x05, 0x10, 0x00 -> ram_addr 0x1000..0x1003 on consecutive cycles; if_done pulses once, 5 cycles after grant; if_data = 0x00100513.
- MEM store half: mem_addr = 0x2001, mem_wdata = 0xDEADBEEF, mem_len = 01 -> ram_wr high for 2 cycles writing 0xEF@0x2001, 0xBE@0x2002; mem_done 2 cycles after grant; ram_wr = 0 afterwards.
- if_req and mem_req rise together, MEM load byte at 0x30 = 0x85 -> MEM served first; mem_rdata = 0x00000085; IF granted after DONE; both done pulses occur exactly once.
- if_req dropped 2 cycles into an IF read, with mem_req pending -> no if_done; state back to IDLE; MEM granted on the next edge.
- rdy held 0 for 3 cycles mid-store word -> ram_wr = 0 and ram_addr frozen during the stall; the write resumes at the same byte; every byte is written once with rdy = 1.
- rst pulled low asynchronously mid-write -> ram_wr, busy and the done outputs go to 0 immediately; IDLE after rst = 1; a new request completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one byte-wide RAM port between instruction fetch and the MEM
// stage, moving 1/2/4-byte little-endian transfers one byte per cycle.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]            mem_len,
  input  logic [31:0]           mem_wdata,
  output logic                  mem_done,
  output logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  owner_q, owner_d;
  logic [2:0]            len_q, len_d;    // transfer length in bytes: 1, 2 or 4
  logic [2:0]            cnt_q, cnt_d;    // RD: edges since grant; WR: byte on the bus
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rbuf_q, rbuf_d;
  logic [1:0]            cap_idx;

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_wr_q, ram_wr_d;
  logic [7:0]            ram_dout_q, ram_dout_d;
  logic                  if_done_q, if_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mem_done_q, mem_done_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  busy_q, busy_d;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    cap_idx     = 2'(cnt_q - 3'd2);

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          owner_d    = OWN_MEM;
          base_d     = mem_addr;
          len_d      = len_bytes(mem_len);
          wdata_d    = mem_wdata;
          rbuf_d     = '0;
          ram_addr_d = mem_addr;
          if (mem_we) begin
            state_d    = WR;
            cnt_d      = 3'd0;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = RD;
            cnt_d   = 3'd1;
          end
        end else if (if_req) begin
          owner_d    = OWN_IF;
          base_d     = if_addr;
          len_d      = 3'd4;
          rbuf_d     = '0;
          ram_addr_d = if_addr;
          state_d    = RD;
          cnt_d      = 3'd1;
        end
      end

      RD: begin
        if (owner_q == OWN_IF && !if_req) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < len_q) ram_addr_d = base_q + ADDR_WIDTH'(cnt_q);
          // RAM returns a byte one cycle after sampling its address, hence the two-edge lag.
          if (cnt_q >= 3'd2) rbuf_d[{cap_idx, 3'b000} +: 8] = ram_din;
          if (cnt_q == len_q + 3'd1) begin
            state_d = DONE;
            if (owner_q == OWN_IF) begin
              if_data_d = rbuf_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = rbuf_d;
              mem_done_d  = 1'b1;
            end
          end
        end
      end

      WR: begin
        // A byte counts as written only once it was on the bus with ram_wr high across an
        // active edge; after a stall the same byte is presented again.
        if (!ram_wr_q) begin
          ram_wr_d = 1'b1;
        end else if (cnt_q == len_q - 3'd1) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = base_q + ADDR_WIDTH'(cnt_q + 3'd1);
          ram_dout_d = byte_of(wdata_q, 2'(cnt_q + 3'd1));
          ram_wr_d   = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      len_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end else begin
      ram_wr_q <= 1'b0;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: byte RAM model plus scoreboard bench for ram_arbiter; directed timing
// scenarios followed by randomized traffic with random rdy stalls.
module tb_ram_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] data;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        busy;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  wr_cnt  [0:65535];

  mem_exp_t    exp_mem[$];
  logic [31:0] exp_if[$];
  logic [31:0] if_data_model = '0;
  logic [31:0] mem_rdata_model = '0;
  logic        last_rdy = 1'b0;
  logic        rand_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Byte RAM: address sampled on active edges, read data one cycle later, frozen when rdy = 0.
  initial forever begin
    @(posedge clk);
    if (rdy) begin
      ram_din <= ram[ram_addr[15:0]];
      if (ram_wr) begin
        ram[ram_addr[15:0]]    = ram_dout;
        wr_cnt[ram_addr[15:0]] = wr_cnt[ram_addr[15:0]] + 8'd1;
      end
    end
  end

  always @(posedge clk) last_rdy <= rdy;

  initial forever begin
    @(negedge clk);
    if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: a done pulse is new when it follows an active edge.
  always @(negedge clk) begin
    mem_exp_t e;
    if (rst && last_rdy && mem_done) begin
      check("mem_done_expected", 32'(exp_mem.size() != 0), 32'd1);
      if (exp_mem.size() != 0) begin
        e = exp_mem.pop_front();
        if (!e.we) mem_rdata_model = e.data;
        check(e.we ? "mem_rdata_hold" : "mem_rdata", mem_rdata, mem_rdata_model);
      end
    end
    if (rst && last_rdy && if_done) begin
      check("if_done_expected", 32'(exp_if.size() != 0), 32'd1);
      if (exp_if.size() != 0) begin
        if_data_model = exp_if.pop_front();
        check("if_data", if_data, if_data_model);
      end
    end
  end

  task automatic wait_done(input logic for_mem, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (last_rdy && (for_mem ? mem_done : if_done)) ok = 1'b1;
    end
  endtask

  task automatic mem_issue(input logic we, input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] wd);
    logic [31:0] want;
    int n;
    n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    want = '0;
    for (int i = 0; i < n; i++) begin
      if (we) ref_mem[16'(addr + 32'(i))] = wd[8*i +: 8];
      else    want[8*i +: 8] = ref_mem[16'(addr + 32'(i))];
    end
    exp_mem.push_back('{we, want});
    mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wd; mem_req = 1'b1;
  endtask

  task automatic if_issue(input logic [31:0] addr);
    logic [31:0] want;
    for (int i = 0; i < 4; i++) want[8*i +: 8] = ref_mem[16'(addr + 32'(i))];
    exp_if.push_back(want);
    if_addr = addr; if_req = 1'b1;
  endtask

  task automatic mem_txn(input logic we, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wd);
    logic ok;
    mem_issue(we, addr, len, wd);
    wait_done(1'b1, ok);
    mem_req = 1'b0;
    check("mem_timeout", 32'(ok), 32'd1);
  endtask

  task automatic if_fetch(input logic [31:0] addr);
    logic ok;
    if_issue(addr);
    wait_done(1'b0, ok);
    if_req = 1'b0;
    check("if_timeout", 32'(ok), 32'd1);
  endtask

  task automatic mem_rand();
    logic [31:0] a;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                    : 32'h0000_0100 + 32'($urandom_range(0, 63));
    mem_txn($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), $urandom);
  endtask

  task automatic if_rand();
    repeat ($urandom_range(1, 4)) @(negedge clk);
    if_fetch(32'h0000_8000 + 32'($urandom_range(0, 255)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int mem_cnt, if_cnt, mem_at, if_at, bad;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 8'(i * 37 + 11) ^ 8'(i >> 8);
      ref_mem[i] = ram[i];
      wr_cnt[i]  = '0;
    end

    // Reset values
    #12;
    check("rst_if_done", 32'(if_done), 0);
    check("rst_mem_done", 32'(mem_done), 0);
    check("rst_ram_wr", 32'(ram_wr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_if_data", if_data, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    check("rst_ram_addr", ram_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;

    // IF word fetch at 0x1000
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h10; ram[16'h1003] = 8'h00;
    ref_mem[16'h1000] = 8'h13; ref_mem[16'h1001] = 8'h05;
    ref_mem[16'h1002] = 8'h10; ref_mem[16'h1003] = 8'h00;
    @(negedge clk);
    if_issue(32'h1000);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 3) check("if_ram_addr", ram_addr, 32'h1000 + 32'(c));
      check("if_done_cycle", 32'(if_done), 32'(c == 5));
      if (c == 5) begin
        check("if_word", if_data, 32'h0010_0513);
        if_req = 1'b0;
      end
    end
    check("busy_after_fetch", 32'(busy), 0);

    // MEM store half at 0x2001
    mem_issue(1'b1, 32'h2001, 2'b01, 32'hDEAD_BEEF);
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      check("sth_ram_wr", 32'(ram_wr), 32'(c < 2));
      if (c < 2) begin
        check("sth_ram_addr", ram_addr, 32'h2001 + 32'(c));
        check("sth_ram_dout", 32'(ram_dout), (c == 0) ? 32'hEF : 32'hBE);
      end
      check("sth_mem_done", 32'(mem_done), 32'(c == 2));
      if (c == 2) mem_req = 1'b0;
    end
    check("sth_byte0", 32'(ram[16'h2001]), 32'hEF);
    check("sth_byte1", 32'(ram[16'h2002]), 32'hBE);

    // Simultaneous requests: MEM byte load first, then IF
    ram[16'h0030] = 8'h85;
    ref_mem[16'h0030] = 8'h85;
    mem_issue(1'b0, 32'h30, 2'b00, '0);
    if_issue(32'h8000);
    mem_cnt = 0; if_cnt = 0; mem_at = -1; if_at = -1;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (mem_done) begin mem_cnt++; mem_at = c; mem_req = 1'b0; end
      if (if_done)  begin if_cnt++;  if_at = c;  if_req = 1'b0;  end
    end
    check("arb_mem_pulses", 32'(mem_cnt), 1);
    check("arb_if_pulses", 32'(if_cnt), 1);
    check("arb_mem_cycle", 32'(mem_at), 2);
    check("arb_if_cycle", 32'(if_at), 9);

    // IF abort two cycles in, with MEM pending
    if_addr = 32'h8100;
    if_req  = 1'b1;
    if_cnt = 0; mem_at = -1;
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      if (if_done) if_cnt++;
      if (mem_done) begin mem_at = c; mem_req = 1'b0; end
      if (c == 1) begin
        if_req = 1'b0;
        mem_issue(1'b0, 32'h40, 2'b10, '0);
      end
      if (c == 2) begin
        check("abort_busy_idle", 32'(busy), 0);
        check("abort_if_data_held", if_data, if_data_model);
      end
      if (c == 3) begin
        check("abort_mem_busy", 32'(busy), 1);
        check("abort_mem_addr", ram_addr, 32'h40);
      end
    end
    check("abort_no_if_done", 32'(if_cnt), 0);
    check("abort_mem_cycle", 32'(mem_at), 8);

    // rdy stall of three edges mid-store word
    mem_issue(1'b1, 32'h3000, 2'b10, 32'h1122_3344);
    for (int c = 0; c <= 8; c++) begin
      logic [31:0] want_addr;
      @(negedge clk);
      want_addr = (c == 0) ? 32'h3000 : (c <= 5) ? 32'h3001 : (c == 6) ? 32'h3002 : 32'h3003;
      check("stall_ram_wr", 32'(ram_wr), 32'((c < 2) || (c >= 5 && c <= 7)));
      if (c <= 7) check("stall_ram_addr", ram_addr, want_addr);
      if (c >= 2 && c <= 5) check("stall_ram_dout", 32'(ram_dout), 32'h33);
      check("stall_mem_done", 32'(mem_done), 32'(c == 8));
      if (c == 1) rdy = 1'b0;
      if (c == 4) rdy = 1'b1;
      if (c == 8) mem_req = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      check("stall_write_once", 32'(wr_cnt[16'h3000 + 16'(i)]), 1);
      check("stall_ram_byte", 32'(ram[16'h3000 + 16'(i)]), 32'(ref_mem[16'h3000 + 16'(i)]));
    end

    // Randomized traffic with random rdy
    rand_rdy = 1'b1;
    for (int it = 0; it < 40; it++) begin
      logic do_mem, do_if;
      do_mem = ($urandom_range(0, 3) != 0);
      do_if  = ($urandom_range(0, 2) != 0);
      fork
        if (do_mem) mem_rand();
        if (do_if) if_rand();
      join
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    rdy = 1'b1;
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-write
    mem_we = 1'b1; mem_addr = 32'h5000; mem_len = 2'b10; mem_wdata = 32'hA1B2_C3D4; mem_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ram_wr", 32'(ram_wr), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_mem_done", 32'(mem_done), 0);
    check("arst_if_done", 32'(if_done), 0);
    check("arst_mem_rdata", mem_rdata, 0);
    check("arst_if_data", if_data, 0);
    mem_req = 1'b0;
    mem_rdata_model = '0;
    if_data_model   = '0;
    ref_mem[16'h5000] = 8'hD4;  // byte 0 reached the RAM before reset hit
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_idle", 32'(busy), 0);
    mem_txn(1'b0, 32'h3000, 2'b10, '0);
    check("arst_reload", mem_rdata, 32'h1122_3344);
    if_fetch(32'h8004);
    repeat (3) @(negedge clk);

    bad = 0;
    for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) bad++;
    check("ram_image_mismatches", 32'(bad), 0);
    check("exp_mem_drained", 32'(exp_mem.size()), 0);
    check("exp_if_drained", 32'(exp_if.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
